sp_ram_arbiter: RTL and testbench

Two-requester round-robin controller that shares one `single_port_sync_ram` (ADDR_WIDTH=4, DATA_WIDTH=16) between two clients. It accepts read/write commands over a valid/ready handshake and sequences the RAM's `cs`/`we`/`oe`/`addr` controls. It owns the bidirectional `data` bus and returns per-port responses. It sits between the client logic and the RAM instance; no other block drives the RAM.

---
 rtl/sp_ram_arbiter_pkg.sv | 25 ++
 rtl/sp_ram_arbiter_rr_grant.sv | 23 ++
 rtl/sp_ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sp_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_arbiter_pkg.sv
// Shared definitions for the two-port round-robin single-port RAM arbiter:
// FSM state encodings and the default RAM geometry.
package sp_ram_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_ADDR = 2'd2,
        ST_RD_DATA = 2'd3
    } state_e;

    // The arbiter owns the data bus only while a write is in progress.
    function automatic logic state_drives_bus(input state_e st);
        return (st == ST_WR);
    endfunction

    // States in which the RAM is selected for a read.
    function automatic logic state_is_read(input state_e st);
        return (st == ST_RD_ADDR) || (st == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/sp_ram_arbiter_rr_grant.sv
// Two-way round-robin grant: picks the single valid port, or on a tie the
// port that was not granted last. Purely combinational.
module sp_ram_rr_grant (
    input  logic valid_0,
    input  logic valid_1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    // Select the winning port from the two valids and the previous winner.
    always_comb begin
        grant_valid = valid_0 | valid_1;
        if (valid_0 && valid_1) begin
            grant = ~last_grant;
        end else if (valid_1) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin controller sharing one synchronous single-port RAM between two
// clients. Commands are taken only in IDLE; writes take one RAM cycle, reads
// take two (address latch, then data capture). RAM controls are decoded from
// the state and command registers only.
module sp_ram_arbiter
    import sp_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_we_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    output logic                  rsp_valid_0,
    output logic [DATA_WIDTH-1:0] rsp_rdata_0,

    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_we_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_rdata_1,

    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    state_e                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    cmd_we_q, cmd_we_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                    cmd_port_q, cmd_port_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata0_q, rsp_rdata0_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata1_q, rsp_rdata1_d;

    logic                    grant_valid_s;
    logic                    grant_s;
    logic                    is_idle_s;

    sp_ram_rr_grant u_grant (
        .valid_0     (req_valid_0),
        .valid_1     (req_valid_1),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid_s),
        .grant       (grant_s)
    );

    assign is_idle_s   = (state_q == ST_IDLE);
    assign req_ready_0 = is_idle_s && grant_valid_s && (grant_s == 1'b0);
    assign req_ready_1 = is_idle_s && grant_valid_s && (grant_s == 1'b1);

    // Next-state, command capture and response generation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_port_d   = cmd_port_q;
        rsp_valid_d  = 2'b00;
        rsp_rdata0_d = rsp_rdata0_q;
        rsp_rdata1_d = rsp_rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    // A grant in IDLE is always a handshake on the granted port.
                    cmd_port_d   = grant_s;
                    last_grant_d = grant_s;
                    if (grant_s) begin
                        cmd_we_d    = req_we_1;
                        cmd_addr_d  = req_addr_1;
                        cmd_wdata_d = req_wdata_1;
                    end else begin
                        cmd_we_d    = req_we_0;
                        cmd_addr_d  = req_addr_0;
                        cmd_wdata_d = req_wdata_0;
                    end
                    state_d = (grant_s ? req_we_1 : req_we_0) ? ST_WR : ST_RD_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                state_d                 = ST_IDLE;
                rsp_valid_d[cmd_port_q] = 1'b1;
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                state_d                 = ST_IDLE;
                rsp_valid_d[cmd_port_q] = 1'b1;
                if (cmd_port_q) begin
                    rsp_rdata1_d = ram_data;
                end else begin
                    rsp_rdata0_d = ram_data;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, command and response registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= {ADDR_WIDTH{1'b0}};
            cmd_wdata_q  <= {DATA_WIDTH{1'b0}};
            cmd_port_q   <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata0_q <= {DATA_WIDTH{1'b0}};
            rsp_rdata1_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_port_q   <= cmd_port_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata0_q <= rsp_rdata0_d;
            rsp_rdata1_q <= rsp_rdata1_d;
        end
    end

    // RAM control decode from the state register.
    always_comb begin
        ram_cs = 1'b0;
        ram_we = 1'b0;
        ram_oe = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ram_cs = 1'b0;
            end
            ST_WR: begin
                ram_cs = 1'b1;
                ram_we = 1'b1;
            end
            ST_RD_ADDR, ST_RD_DATA: begin
                ram_cs = 1'b1;
                ram_oe = state_is_read(state_q);
            end
            default: begin
                ram_cs = 1'b0;
            end
        endcase
    end

    assign ram_addr    = cmd_addr_q;
    assign ram_data    = state_drives_bus(state_q) ? cmd_wdata_q : {DATA_WIDTH{1'bz}};
    assign rsp_valid_0 = rsp_valid_q[0];
    assign rsp_valid_1 = rsp_valid_q[1];
    assign rsp_rdata_0 = rsp_rdata0_q;
    assign rsp_rdata_1 = rsp_rdata1_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: behavioural RAM, directed command
// table, full-depth sweep, contended traffic against a reference model, and
// reset during a read.
module tb_sp_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_0, req_we_0, req_valid_1, req_we_1;
    logic [AW-1:0] req_addr_0, req_addr_1;
    logic [DW-1:0] req_wdata_0, req_wdata_1;
    logic          req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
    logic [DW-1:0] rsp_rdata_0, rsp_rdata_1;
    logic          ram_cs, ram_we, ram_oe;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] model_mem [16];
    int model_last;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    // Behavioural single_port_sync_ram
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
        else if (ram_cs && ram_oe) ram_q <= ram_mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus-protocol monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) check("we_without_oe", {31'd0, ram_oe}, 32'd0);
            if (ram_we) check("we_needs_cs", {31'd0, ram_cs}, 32'd1);
            if (!ram_cs) check("bus_released", {31'd0, ram_data === {DW{1'bz}}}, 32'd1);
        end
    end

    function automatic logic get_ready(input int p);
        return (p == 0) ? req_ready_0 : req_ready_1;
    endfunction
    function automatic logic get_rsp(input int p);
        return (p == 0) ? rsp_valid_0 : rsp_valid_1;
    endfunction
    function automatic logic [DW-1:0] get_rdata(input int p);
        return (p == 0) ? rsp_rdata_0 : rsp_rdata_1;
    endfunction

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req_valid_0 = v; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d;
        end else begin
            req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d;
        end
    endtask

    // One command on one port; returns at the negedge where rsp_valid is seen.
    task automatic do_cmd(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit b2b, output logic [DW-1:0] rd);
        int w = 0;
        int edges = 1;
        int we_cnt = 0;
        bit got = 0;
        rd = '0;
        set_req(p, 1'b1, we, a, d);
        #1;
        while (!get_ready(p) && w < 20) begin
            @(negedge clk); #1; w++;
        end
        check("handshake_timeout", {31'd0, w < 20}, 32'd1);
        if (w >= 20) begin
            set_req(p, 1'b0, 1'b0, '0, '0);
            return;
        end
        if (b2b) check("no_bubble", w, 32'd0);
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, '0, '0);
        model_last = p;
        if (we) model_mem[a] = d;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ram_we) we_cnt++;
            check("other_rsp_quiet", {31'd0, get_rsp(1 - p)}, 32'd0);
            if (get_rsp(p)) begin got = 1; break; end
            @(posedge clk);
            edges++;
        end
        check("rsp_seen", {31'd0, got}, 32'd1);
        check(we ? "wr_latency" : "rd_latency", edges, we ? 32'd2 : 32'd3);
        check("we_cycles", we_cnt, we ? 32'd1 : 32'd0);
        rd = get_rdata(p);
    endtask

    // Two-port traffic against the reference model. mode 0: random;
    // mode 1: port 0 writes addr i with i*0101, port 1 keeps reading addr 15.
    task automatic run_traffic(input int mode, input int ncycles);
        bit            pv [2];
        logic          pwe [2];
        logic [AW-1:0] pa [2];
        logic [DW-1:0] pd [2];
        int  out_cnt = 0, out_port = 0, seq0 = 0, cyc = 0, g;
        bit  out_rd = 0, gen_en, exp0, exp1;
        logic [DW-1:0] out_data = '0;
        int  grants [2];
        pv[0] = 0; pv[1] = 0; grants[0] = 0; grants[1] = 0;
        @(negedge clk);
        forever begin
            gen_en = (cyc < ncycles) && !(mode == 1 && seq0 >= 16);
            if (!gen_en && out_cnt == 0 && !pv[0] && !pv[1]) break;
            if (cyc >= ncycles + 200) begin
                check("traffic_timeout", 32'd1, 32'd0);
                break;
            end
            exp0 = 0; exp1 = 0;
            if (out_cnt > 0) begin
                out_cnt--;
                if (out_cnt == 0) begin
                    if (out_port == 0) exp0 = 1; else exp1 = 1;
                end
            end
            check("rsp_valid_0", {31'd0, rsp_valid_0}, {31'd0, exp0});
            check("rsp_valid_1", {31'd0, rsp_valid_1}, {31'd0, exp1});
            if (out_rd && (exp0 || exp1))
                check("rsp_rdata", get_rdata(out_port), {16'd0, out_data});
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && gen_en) begin
                    if (mode == 0) begin
                        if ($urandom_range(0, 2) != 0) begin
                            pv[p] = 1; pwe[p] = 1'($urandom_range(0, 1));
                            pa[p] = 4'($urandom_range(0, 15)); pd[p] = 16'($urandom);
                        end
                    end else if (p == 0) begin
                        pv[0] = 1; pwe[0] = 1'b1; pa[0] = 4'(seq0); pd[0] = 16'(seq0 * 16'h0101);
                    end else begin
                        pv[1] = 1; pwe[1] = 1'b0; pa[1] = 4'd15; pd[1] = 16'h0000;
                    end
                end
                set_req(p, pv[p], pv[p] ? pwe[p] : 1'b0, pv[p] ? pa[p] : 4'd0, pv[p] ? pd[p] : 16'd0);
            end
            #1;
            g = -1;
            if (out_cnt == 0) begin
                if (pv[0] && pv[1]) g = 1 - model_last;
                else if (pv[0]) g = 0;
                else if (pv[1]) g = 1;
            end
            check("req_ready_0", {31'd0, req_ready_0}, {31'd0, g == 0});
            check("req_ready_1", {31'd0, req_ready_1}, {31'd0, g == 1});
            @(posedge clk);
            if (g >= 0) begin
                if (pwe[g]) begin
                    model_mem[pa[g]] = pd[g]; out_rd = 0; out_cnt = 2;
                end else begin
                    out_data = model_mem[pa[g]]; out_rd = 1; out_cnt = 3;
                end
                out_port = g; model_last = g; pv[g] = 0; grants[g]++;
                if (mode == 1 && g == 0) seq0++;
                #1 set_req(g, 1'b0, 1'b0, '0, '0);
            end
            @(negedge clk);
            cyc++;
        end
        if (mode == 1) begin
            check("alt_grants_0", grants[0], 32'd16);
            check("alt_grants_1", grants[1], 32'd16);
        end
    endtask

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] v;
        tbl[0] = '{0, 1'b1, 4'd3,  16'hA5A5, 16'h0000};
        tbl[1] = '{0, 1'b0, 4'd3,  16'h0000, 16'hA5A5};
        tbl[2] = '{1, 1'b1, 4'd15, 16'h1234, 16'h0000};
        tbl[3] = '{1, 1'b0, 4'd15, 16'h0000, 16'h1234};
        tbl[4] = '{0, 1'b1, 4'd0,  16'hBEEF, 16'h0000};
        tbl[5] = '{1, 1'b0, 4'd0,  16'h0000, 16'hBEEF};
        tbl[6] = '{1, 1'b1, 4'd3,  16'h0F0F, 16'h0000};
        tbl[7] = '{0, 1'b0, 4'd3,  16'h0000, 16'h0F0F};

        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        model_last = 1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs", {31'd0, ram_cs}, 32'd0);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        check("rst_oe", {31'd0, ram_oe}, 32'd0);
        check("rst_addr", {28'd0, ram_addr}, 32'd0);
        check("rst_bus_z", {31'd0, ram_data === {DW{1'bz}}}, 32'd1);
        check("rst_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        check("rst_rdata0", {16'd0, rsp_rdata_0}, 32'd0);
        check("rst_rdata1", {16'd0, rsp_rdata_1}, 32'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
            check("idle_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
            check("idle_cs", {31'd0, ram_cs}, 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            do_cmd(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, i > 0, rd);
            if (!tbl[i].we) check("tbl_rdata", {16'd0, rd}, {16'd0, tbl[i].exp});
        end

        for (int a = 0; a < 16; a++) begin
            v = 16'($urandom);
            do_cmd(1, 1'b1, 4'(a), v, 1'b1, rd);
        end
        for (int a = 0; a < 16; a++) begin
            do_cmd(1, 1'b0, 4'(a), 16'h0000, 1'b1, rd);
            check("sweep_rdata", {16'd0, rd}, {16'd0, model_mem[a]});
        end

        run_traffic(1, 400);
        run_traffic(0, 300);

        do_cmd(0, 1'b1, 4'd5, 16'hC3C3, 1'b0, rd);
        set_req(0, 1'b1, 1'b0, 4'd5, 16'h0000);
        #1 check("rd_ready", {31'd0, req_ready_0}, 32'd1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #2;
        check("in_rd_data_oe", {31'd0, ram_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_bus_z", {31'd0, ram_data === {DW{1'bz}}}, 32'd1);
        check("midrst_cs", {31'd0, ram_cs}, 32'd0);
        check("midrst_rdata0", {16'd0, rsp_rdata_0}, 32'd0);
        model_last = 1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        set_req(0, 1'b1, 1'b0, 4'd5, 16'h0000);
        set_req(1, 1'b1, 1'b0, 4'd2, 16'h0000);
        #1 check("tie_after_rst", {30'd0, req_ready_1, req_ready_0}, 32'd1);
        set_req(1, 1'b0, 1'b0, '0, '0);
        do_cmd(0, 1'b0, 4'd5, 16'h0000, 1'b0, rd);
        check("post_rst_rdata", {16'd0, rd}, 32'h0000C3C3);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
